// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: opcodes, the prefetch queue entry and B-type immediate decode.
package riscv_pkg;

    localparam int PC_W = 12;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic            bpr;
    } ifq_entry_t;

    // Sign-extended B-type branch offset; bit 0 is always zero.
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head is read combinationally.
module ifq_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  ifq_entry_t                 wrData,
    output ifq_entry_t                 rdData,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_entry_t             mem [DEPTH];
    logic [PTR_W-1:0]       wrPtr;
    logic [PTR_W-1:0]       rdPtr;
    logic [CNT_W-1:0]       count;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign occupancy = count;
    assign rdData    = mem[rdPtr];

    // NOTE: storage is not reset; every read is qualified by count, so stale words are never consumed.
    always_ff @(posedge CLK) begin
        if (push && !flush)
            mem[wrPtr] <= wrData;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch stage with prefetch queue, EX redirect and sticky halt.
// Define IFQ_BTFN_PREDICT_EN for static backward-taken/forward-not-taken branch prediction.
module if_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = riscv_pkg::PC_W,  // must match the entry type width
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    output logic                   I_MEM_CSN,
    output logic [PC_W-1:0]        I_MEM_ADDR,
    input  logic [31:0]            I_MEM_DI,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    input  logic                   halt_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_bpr,
    output logic [$clog2(DEPTH):0] occupancy
);

    logic [PC_W-1:0] fetchPc;
    logic [PC_W-1:0] nextPc;
    logic            halted;
    logic            predTaken;
    logic            push;
    logic            pop;
    logic            qEmpty;
    logic            qFull;
    ifq_entry_t      wrEntry;
    ifq_entry_t      headEntry;

    assign I_MEM_CSN  = ~RSTn;
    assign I_MEM_ADDR = fetchPc;

    // Redirect masks the handshake so decode never consumes an entry being flushed.
    assign out_valid = ~qEmpty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = ~halted & ~redirect_valid & (~qFull | pop);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        predTaken = 1'b0;
        nextPc    = fetchPc + PC_W'(4);
`ifdef IFQ_BTFN_PREDICT_EN
        if (I_MEM_DI[6:0] == OPC_BRANCH && I_MEM_DI[31]) begin
            predTaken = 1'b1;
            nextPc    = fetchPc + PC_W'(b_imm(I_MEM_DI));
        end
`endif
    end

    assign wrEntry = '{inst: I_MEM_DI, pc: fetchPc, bpr: predTaken};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetchPc <= RESET_PC;
            halted  <= 1'b0;
        end else begin
            if (redirect_valid)
                fetchPc <= redirect_pc;
            else if (push)
                fetchPc <= nextPc;
            if (halt_i)
                halted <= 1'b1;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .wrData    (wrEntry),
        .rdData    (headEntry),
        .occupancy (occupancy),
        .empty     (qEmpty),
        .full      (qFull)
    );

    // Head fields read as zero when the queue is empty.
    assign out_inst = qEmpty ? '0 : headEntry.inst;
    assign out_pc   = qEmpty ? '0 : headEntry.pc;
`ifdef IFQ_BTFN_PREDICT_EN
    assign out_bpr  = ~qEmpty & headEntry.bpr;
`else
    assign out_bpr  = 1'b0;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: sequential fetch, backpressure, redirect, halt, PC wrap, prediction.
module tb_if_prefetch_queue;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    always #5 CLK = ~CLK;

    logic        csnA, validA, readyA, bprA, redirValid, haltI;
    logic [11:0] addrA, pcA, redirPc;
    logic [31:0] diA, instA;
    logic [2:0]  occA;

    logic        csnB, validB, readyB, bprB;
    logic [11:0] addrB, pcB;
    logic [31:0] diB, instB;
    logic [2:0]  occB;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memWord(input logic [11:0] a);
        return (a == 12'h020) ? 32'hFE000CE3 : 32'h00000013;
    endfunction

    assign diA = memWord(addrA);
    assign diB = memWord(addrB);

    if_prefetch_queue dut (
        .CLK(CLK), .RSTn(RSTn), .I_MEM_CSN(csnA), .I_MEM_ADDR(addrA), .I_MEM_DI(diA),
        .redirect_valid(redirValid), .redirect_pc(redirPc), .halt_i(haltI),
        .out_valid(validA), .out_ready(readyA), .out_inst(instA), .out_pc(pcA),
        .out_bpr(bprA), .occupancy(occA)
    );

    if_prefetch_queue #(.RESET_PC(12'hFF8)) dutWrap (
        .CLK(CLK), .RSTn(RSTn), .I_MEM_CSN(csnB), .I_MEM_ADDR(addrB), .I_MEM_DI(diB),
        .redirect_valid(1'b0), .redirect_pc(12'h000), .halt_i(1'b0),
        .out_valid(validB), .out_ready(readyB), .out_inst(instB), .out_pc(pcB),
        .out_bpr(bprB), .occupancy(occB)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic doReset(input logic ready);
        RSTn       = 1'b0;
        readyA     = ready;
        redirValid = 1'b0;
        haltI      = 1'b0;
        step();
        step();
        RSTn = 1'b1;
    endtask

`ifdef IFQ_BTFN_PREDICT_EN
    localparam logic        EXP_BPR  = 1'b1;
    localparam logic [11:0] EXP_NEXT = 12'h018;
`else
    localparam logic        EXP_BPR  = 1'b0;
    localparam logic [11:0] EXP_NEXT = 12'h024;
`endif

    initial begin
        readyA = 1'b1; readyB = 1'b1; redirValid = 1'b0; redirPc = '0; haltI = 1'b0;
        @(negedge CLK);
        step();

        // Reset state
        check("rst_valid", 32'(validA), 32'h0);
        check("rst_occ",   32'(occA),   32'h0);
        check("rst_csn",   32'(csnA),   32'h1);
        check("rst_addr",  32'(addrA),  32'h000);
        check("rst_pc",    32'(pcA),    32'h0);
        check("rst_inst",  instA,       32'h0);
        check("rst_bpr",   32'(bprA),   32'h0);
        check("rst_addrB", 32'(addrB),  32'hFF8);
        RSTn = 1'b1;
        #1;
        check("run_csn", 32'(csnA), 32'h0);

        // Sequential fetch, one entry per cycle; second instance wraps past 0xFFC
        for (int k = 0; k < 4; k++) begin
            step();
            check("seq_valid", 32'(validA), 32'h1);
            check("seq_pc",    32'(pcA),    32'(4 * k));
            check("seq_inst",  instA,       32'h00000013);
            check("wrap_pc",   32'(pcB),    32'(12'(12'hFF8 + 12'(4 * k))));
        end
        check("seq_occ", 32'(occA), 32'h1);

        // Backpressure: saturate, then drain with no gap
        doReset(1'b0);
        step();
        check("bp_occ1", 32'(occA), 32'h1);
        for (int k = 0; k < 9; k++) step();
        check("bp_occ_full", 32'(occA),  32'h4);
        check("bp_addr",     32'(addrA), 32'h010);
        readyA = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_valid", 32'(validA), 32'h1);
            check("drain_pc",    32'(pcA),    32'(4 * k));
            step();
        end
        check("drain_occ", 32'(occA), 32'h4);

        // Redirect with three entries queued
        doReset(1'b0);
        step(); step(); step();
        check("rd_occ3", 32'(occA), 32'h3);
        readyA = 1'b1; redirValid = 1'b1; redirPc = 12'h100;
        #1;
        check("rd_valid_masked", 32'(validA), 32'h0);
        step();
        redirValid = 1'b0;
        #1;
        check("rd_occ0",   32'(occA),   32'h0);
        check("rd_bubble", 32'(validA), 32'h0);
        check("rd_addr",   32'(addrA),  32'h100);
        step();
        check("rd_valid", 32'(validA), 32'h1);
        check("rd_pc0",   32'(pcA),    32'h100);
        step();
        check("rd_pc1",   32'(pcA),    32'h104);

        // Halt with two entries queued: the halt edge itself still pushes 0x008
        doReset(1'b0);
        step(); step();
        check("h_occ2", 32'(occA), 32'h2);
        haltI = 1'b1;
        step();
        haltI = 1'b0;
        check("h_occ3",  32'(occA),  32'h3);
        check("h_addr0", 32'(addrA), 32'h00C);
        step();
        check("h_occ_hold",  32'(occA),  32'h3);
        check("h_addr_hold", 32'(addrA), 32'h00C);
        readyA = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("h_drain_pc", 32'(pcA), 32'(4 * k));
            step();
        end
        check("h_empty_valid", 32'(validA), 32'h0);
        check("h_empty_occ",   32'(occA),   32'h0);
        step(); step(); step();
        check("h_stay_valid", 32'(validA), 32'h0);
        check("h_stay_addr",  32'(addrA),  32'h00C);
        redirValid = 1'b1; redirPc = 12'h200;
        step();
        redirValid = 1'b0;
        check("h_redir_addr", 32'(addrA), 32'h200);
        step(); step();
        check("h_redir_valid", 32'(validA), 32'h0);
        check("h_redir_occ",   32'(occA),   32'h0);

        // Backward branch at 0x020
        doReset(1'b1);
        for (int k = 0; k < 9; k++) step();
        check("br_pc",   32'(pcA),  32'h020);
        check("br_inst", instA,     32'hFE000CE3);
        check("br_bpr",  32'(bprA), 32'(EXP_BPR));
        step();
        check("br_next_pc",  32'(pcA),  32'(EXP_NEXT));
        check("br_next_bpr", 32'(bprA), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
